// File: rtl/ddr4_cmd_scheduler_pkg.sv
// Shared types and constants for the DDR4 command scheduler.
// The command triplets are the RAS_n/CAS_n/WE_n values that ride on A16/A15/A14.
package ddr4_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_CAS,
    ST_CAS_WAIT,
    ST_BURST
  } state_t;

  // {RAS_n, CAS_n, WE_n}
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;

  // A-bus bit positions that carry command meaning
  localparam int A_RAS_N = 16;
  localparam int A_CAS_N = 15;
  localparam int A_WE_N  = 14;
  localparam int A_AP    = 10;

  // Column command triplet for a read or a write
  function automatic logic [2:0] cas_code(input logic write);
    return write ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/ddr4_cmd_scheduler_if.sv
// Request-side and DIMM-side bundles of the DDR4 command scheduler.
// The scheduler is the slave of the request bundle and the master of the command bundle.
interface ddr4_req_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [BGWIDTH-1:0]   req_bg;
  logic [BAWIDTH-1:0]   req_ba;
  logic [ADDRWIDTH-1:0] req_row;
  logic [COLWIDTH-1:0]  req_col;

  modport master (
    output req_valid, req_write, req_bg, req_ba, req_row, req_col,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_write, req_bg, req_ba, req_row, req_col,
    output req_ready
  );
endinterface

interface ddr4_cmd_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17
);
  logic                 stall;
  logic                 cke;
  logic                 cs_n;
  logic                 act_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic                 data_phase;
  logic                 data_write;

  modport master (
    input  stall,
    output cke, cs_n, act_n, A, bg, ba, data_phase, data_write
  );

  modport slave (
    output stall,
    input  cke, cs_n, act_n, A, bg, ba, data_phase, data_write
  );
endinterface

// File: rtl/ddr4_cmd_scheduler_bank_table.sv
// Open-page bookkeeping: one open bit and one row register per bank.
// Lookup is combinational; updates land on the clock edge.
module ddr4_bank_table #(
  parameter int IDXW = 4,
  parameter int ROWW = 17
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IDXW-1:0] lk_idx_i,
  input  logic [ROWW-1:0] lk_row_i,
  output logic            lk_open_o,
  output logic            lk_hit_o,
  input  logic            upd_en_i,
  input  logic            upd_set_i,
  input  logic [IDXW-1:0] upd_idx_i,
  input  logic [ROWW-1:0] upd_row_i
);
  localparam int NBANK = 1 << IDXW;

  logic [NBANK-1:0] open_vec;
  logic [ROWW-1:0]  row_arr [NBANK];

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      logic            open_q;
      logic [ROWW-1:0] row_q;

      // Open bit: set on ACT, cleared on PRE, wiped by reset
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          open_q <= 1'b0;
        end else if (upd_en_i && upd_idx_i == IDXW'(gi)) begin
          open_q <= upd_set_i;
        end
      end

      // Row register only matters while the open bit is set, so it needs no reset
      always_ff @(posedge clk) begin
        if (upd_en_i && upd_set_i && upd_idx_i == IDXW'(gi)) begin
          row_q <= upd_row_i;
        end
      end

      assign open_vec[gi] = open_q;
      assign row_arr[gi]  = row_q;
    end
  endgenerate

  assign lk_open_o = open_vec[lk_idx_i];
  assign lk_hit_o  = lk_open_o && (row_arr[lk_idx_i] == lk_row_i);

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// Single-requester DDR4 command sequencer with an open-page policy.
// Command pins are registered; stall only masks cs_n/act_n/req_ready combinationally
// so a command held in PRE/ACT/CAS goes out on the first unstalled cycle.
module ddr4_cmd_scheduler
  import ddr4_sched_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRP       = 4,
  parameter int TRCD      = 4,
  parameter int TCL       = 5,
  parameter int TCWL      = 4,
  parameter int CNTWIDTH  = 6
) (
  input logic        clk,
  input logic        reset_n,
  ddr4_req_if.slave  req,
  ddr4_cmd_if.master cmd
);
  localparam int IDXW = BGWIDTH + BAWIDTH;

  state_t               state_q;
  logic                 cke_q, ready_q, cs_n_q, act_n_q;
  logic                 data_phase_q, data_write_q;
  logic [ADDRWIDTH-1:0] a_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [CNTWIDTH-1:0]  wait_q, beat_q;

  // Latched request
  logic                 lat_write_q;
  logic [BGWIDTH-1:0]   lat_bg_q;
  logic [BAWIDTH-1:0]   lat_ba_q;
  logic [ADDRWIDTH-1:0] lat_row_q;
  logic [COLWIDTH-1:0]  lat_col_q;

  logic                 accept_d, issue_pre_d, issue_act_d, issue_cas_d;
  logic                 lk_open_d, lk_hit_d, upd_en_d, upd_set_d;
  logic                 cur_write_d;
  logic [BGWIDTH-1:0]   cur_bg_d;
  logic [BAWIDTH-1:0]   cur_ba_d;
  logic [ADDRWIDTH-1:0] cur_row_d;
  logic [COLWIDTH-1:0]  cur_col_d;
  logic [ADDRWIDTH-1:0] a_pre_d, a_cas_d;
  logic [CNTWIDTH-1:0]  cas_lat_d;

  assign accept_d = req.req_valid & ready_q & ~cmd.stall;

  // In IDLE the first command is issued straight from the incoming request
  assign cur_write_d = (state_q == ST_IDLE) ? req.req_write : lat_write_q;
  assign cur_bg_d    = (state_q == ST_IDLE) ? req.req_bg    : lat_bg_q;
  assign cur_ba_d    = (state_q == ST_IDLE) ? req.req_ba    : lat_ba_q;
  assign cur_row_d   = (state_q == ST_IDLE) ? req.req_row   : lat_row_q;
  assign cur_col_d   = (state_q == ST_IDLE) ? req.req_col   : lat_col_q;

  assign cas_lat_d = lat_write_q ? CNTWIDTH'(TCWL) : CNTWIDTH'(TCL);

  // Table is touched when a PRE or ACT actually leaves the pins
  assign upd_en_d  = ~cmd.stall & ((state_q == ST_PRE) | (state_q == ST_ACT));
  assign upd_set_d = (state_q == ST_ACT);

  ddr4_bank_table #(
    .IDXW (IDXW),
    .ROWW (ADDRWIDTH)
  ) u_bank_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .lk_idx_i  ({req.req_bg, req.req_ba}),
    .lk_row_i  (req.req_row),
    .lk_open_o (lk_open_d),
    .lk_hit_o  (lk_hit_d),
    .upd_en_i  (upd_en_d),
    .upd_set_i (upd_set_d),
    .upd_idx_i ({lat_bg_q, lat_ba_q}),
    .upd_row_i (lat_row_q)
  );

  // A-bus images for PRE (single bank) and RD/WR (no auto-precharge)
  always_comb begin
    a_pre_d = '0;
    {a_pre_d[A_RAS_N], a_pre_d[A_CAS_N], a_pre_d[A_WE_N]} = CMD_PRE;
    a_pre_d[A_AP] = 1'b0;
    a_cas_d = '0;
    {a_cas_d[A_RAS_N], a_cas_d[A_CAS_N], a_cas_d[A_WE_N]} = cas_code(cur_write_d);
    a_cas_d[A_AP] = 1'b0;
    a_cas_d[COLWIDTH-1:0] = cur_col_d;
  end

  // Decide which command, if any, is loaded onto the pins at the coming edge
  always_comb begin
    issue_pre_d = 1'b0;
    issue_act_d = 1'b0;
    issue_cas_d = 1'b0;
    if (!cmd.stall) begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            if (lk_hit_d)       issue_cas_d = 1'b1;
            else if (lk_open_d) issue_pre_d = 1'b1;
            else                issue_act_d = 1'b1;
          end
        end
        ST_PRE:      issue_act_d = (TRP == 1);
        ST_PRE_WAIT: issue_act_d = (wait_q == CNTWIDTH'(1));
        ST_ACT:      issue_cas_d = (TRCD == 1);
        ST_ACT_WAIT: issue_cas_d = (wait_q == CNTWIDTH'(1));
        default: ;
      endcase
    end
  end

  // Sequencer: state, wait/beat counters and registered pin values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cke_q        <= 1'b0;
      ready_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      act_n_q      <= 1'b1;
      a_q          <= '0;
      bg_q         <= '0;
      ba_q         <= '0;
      data_phase_q <= 1'b0;
      data_write_q <= 1'b0;
      wait_q       <= '0;
      beat_q       <= '0;
      lat_write_q  <= 1'b0;
      lat_bg_q     <= '0;
      lat_ba_q     <= '0;
      lat_row_q    <= '0;
      lat_col_q    <= '0;
    end else begin
      cke_q <= 1'b1;
      if (!cmd.stall) begin
        cs_n_q  <= 1'b1;
        act_n_q <= 1'b1;
        case (state_q)
          ST_IDLE: begin
            // ready follows cke by one cycle after reset release
            ready_q <= cke_q;
            if (accept_d) begin
              ready_q     <= 1'b0;
              lat_write_q <= req.req_write;
              lat_bg_q    <= req.req_bg;
              lat_ba_q    <= req.req_ba;
              lat_row_q   <= req.req_row;
              lat_col_q   <= req.req_col;
            end
          end
          ST_PRE: begin
            if (TRP > 1) begin
              state_q <= ST_PRE_WAIT;
              wait_q  <= CNTWIDTH'(TRP - 1);
            end
          end
          ST_PRE_WAIT, ST_ACT_WAIT: wait_q <= wait_q - CNTWIDTH'(1);
          ST_ACT: begin
            if (TRCD > 1) begin
              state_q <= ST_ACT_WAIT;
              wait_q  <= CNTWIDTH'(TRCD - 1);
            end
          end
          ST_CAS: begin
            if (cas_lat_d > CNTWIDTH'(1)) begin
              state_q <= ST_CAS_WAIT;
              wait_q  <= cas_lat_d - CNTWIDTH'(1);
            end else begin
              state_q      <= ST_BURST;
              data_phase_q <= 1'b1;
              beat_q       <= CNTWIDTH'(BL);
            end
          end
          ST_CAS_WAIT: begin
            if (wait_q == CNTWIDTH'(1)) begin
              state_q      <= ST_BURST;
              data_phase_q <= 1'b1;
              beat_q       <= CNTWIDTH'(BL);
            end else begin
              wait_q <= wait_q - CNTWIDTH'(1);
            end
          end
          ST_BURST: begin
            if (beat_q == CNTWIDTH'(1)) begin
              state_q      <= ST_IDLE;
              data_phase_q <= 1'b0;
              ready_q      <= 1'b1;
            end else begin
              beat_q <= beat_q - CNTWIDTH'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase

        if (issue_pre_d) begin
          state_q <= ST_PRE;
          cs_n_q  <= 1'b0;
          a_q     <= a_pre_d;
          bg_q    <= cur_bg_d;
          ba_q    <= cur_ba_d;
        end
        if (issue_act_d) begin
          state_q <= ST_ACT;
          cs_n_q  <= 1'b0;
          act_n_q <= 1'b0;
          a_q     <= cur_row_d;
          bg_q    <= cur_bg_d;
          ba_q    <= cur_ba_d;
        end
        if (issue_cas_d) begin
          state_q      <= ST_CAS;
          cs_n_q       <= 1'b0;
          a_q          <= a_cas_d;
          bg_q         <= cur_bg_d;
          ba_q         <= cur_ba_d;
          data_write_q <= cur_write_d;
        end
      end
    end
  end

  assign req.req_ready  = ready_q & ~cmd.stall;
  assign cmd.cke        = cke_q;
  assign cmd.cs_n       = cs_n_q | cmd.stall;
  assign cmd.act_n      = act_n_q | cmd.stall;
  assign cmd.A          = a_q;
  assign cmd.bg         = bg_q;
  assign cmd.ba         = ba_q;
  assign cmd.data_phase = data_phase_q;
  assign cmd.data_write = data_write_q;

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Bench for ddr4_cmd_scheduler: directed test-plan cases followed by random traffic.
// Expected pins come from a per-transaction timeline (command offsets from the timing
// rules) where every stalled cycle simply freezes the timeline for one cycle.
module tb_ddr4_cmd_scheduler;
  localparam int BGW = 2, BAW = 2, AW = 17, CW = 10;
  localparam int BL = 8, TRP = 4, TRCD = 4, TCL = 5, TCWL = 4;

  logic clk;
  logic reset_n;

  ddr4_req_if #(.BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW)) req_bus ();
  ddr4_cmd_if #(.BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW)) cmd_bus ();

  ddr4_cmd_scheduler #(
    .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW), .BL(BL),
    .TRP(TRP), .TRCD(TRCD), .TCL(TCL), .TCWL(TCWL), .CNTWIDTH(6)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_bus),
    .cmd     (cmd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Reference bank table
  logic [15:0]   m_open;
  logic [AW-1:0] m_row [16];

  // What the held A/bg/ba pins should show between commands
  logic [AW-1:0] exp_a, exp_mask;
  logic [3:0]    exp_bgba;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctrl_pins();
    return {cmd_bus.cs_n, cmd_bus.act_n, cmd_bus.data_phase, req_bus.req_ready};
  endfunction

  // Assert reset asynchronously, check reset values, release, check cke/ready ramp
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_val("rst_pins", {cmd_bus.cke, cmd_bus.cs_n, cmd_bus.act_n, cmd_bus.data_phase,
                           cmd_bus.data_write, req_bus.req_ready}, 6'b011000);
    check_val("rst_A", cmd_bus.A, 0);
    check_val("rst_bgba", {cmd_bus.bg, cmd_bus.ba}, 0);
    m_open   = '0;
    exp_a    = '0;
    exp_mask = '1;
    exp_bgba = '0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("cke_rise", {cmd_bus.cke, req_bus.req_ready}, 2'b10);
    @(posedge clk); #1;
    check_val("ready_rise", {cmd_bus.cke, req_bus.req_ready}, 2'b11);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_ctrl", ctrl_pins(), 4'b1101);
      check_val("idle_A", cmd_bus.A & exp_mask, exp_a & exp_mask);
      check_val("idle_bgba", {cmd_bus.bg, cmd_bus.ba}, exp_bgba);
      @(posedge clk); #1;
    end
  endtask

  // One request from accept to return to IDLE. Stall is held for s_len cycles once the
  // timeline reaches offset s_start. abort_off >= 0 pulses reset that many beats into the burst.
  task automatic run_txn(input logic wr, input logic [1:0] tbg, input logic [1:0] tba,
                         input logic [AW-1:0] trow, input logic [CW-1:0] tcol,
                         input int s_start, input int s_len, input int abort_off);
    int idx, tpre, tact, tcas, lat, e, a, scnt;
    logic stl, is_cmd, exp_dp;
    logic [AW-1:0] a_cas, ea, em;
    string path;
    idx = int'({tbg, tba});
    lat = wr ? TCWL : TCL;
    if (!m_open[idx]) begin
      path = "ACT"; tpre = -1; tact = 1; tcas = 1 + TRCD;
    end else if (m_row[idx] != trow) begin
      path = "PRE"; tpre = 1; tact = 1 + TRP; tcas = 1 + TRP + TRCD;
    end else begin
      path = "HIT"; tpre = -1; tact = -1; tcas = 1;
    end
    e = tcas + lat + BL;
    m_open[idx] = 1'b1;
    m_row[idx]  = trow;
    a_cas = '0;
    a_cas[16:14] = wr ? 3'b100 : 3'b101;
    a_cas[CW-1:0] = tcol;
    n_txn++;
    $display("txn %0d: %s bg=%0d ba=%0d row=0x%0h col=0x%0h path=%s stall=%0d@%0d abort=%0d",
             n_txn, wr ? "WR" : "RD", tbg, tba, trow, tcol, path, s_len, s_start, abort_off);

    req_bus.req_valid = 1'b1;
    req_bus.req_write = wr;
    req_bus.req_bg    = tbg;
    req_bus.req_ba    = tba;
    req_bus.req_row   = trow;
    req_bus.req_col   = tcol;
    cmd_bus.stall     = 1'b0;
    @(negedge clk);
    check_val("accept_ctrl", ctrl_pins(), 4'b1101);
    @(posedge clk); #1;
    req_bus.req_valid = 1'b0;

    a = 1;
    scnt = 0;
    while (a < e) begin
      stl = (a == s_start) && (scnt < s_len);
      if (stl) scnt++;
      cmd_bus.stall = stl;
      @(negedge clk);
      is_cmd = (a == tpre) || (a == tact) || (a == tcas);
      exp_dp = (a >= tcas + lat);
      check_val("ctrl", ctrl_pins(), {stl | ~is_cmd, stl | (a != tact), exp_dp, 1'b0});
      if (a >= tcas) begin
        ea = a_cas; em = '1;
      end else if (tact > 0 && a >= tact) begin
        ea = trow; em = '1;
      end else begin
        ea = 17'h08000; em = 17'h1C400;
      end
      check_val("A", cmd_bus.A & em, ea & em);
      check_val("bgba", {cmd_bus.bg, cmd_bus.ba}, {tbg, tba});
      if (exp_dp) check_val("data_write", cmd_bus.data_write, wr);
      if (abort_off >= 0 && a == tcas + lat + abort_off) begin
        cmd_bus.stall = 1'b0;
        apply_reset();
        return;
      end
      @(posedge clk); #1;
      if (!stl) a++;
    end
    cmd_bus.stall = 1'b0;
    exp_a    = a_cas;
    exp_mask = '1;
    exp_bgba = {tbg, tba};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          wr;
    logic [1:0]    tbg, tba;
    logic [AW-1:0] trow;
    logic [CW-1:0] tcol;
    int            s_start, s_len;

    reset_n = 1'b1;
    req_bus.req_valid = 1'b0;
    req_bus.req_write = 1'b0;
    req_bus.req_bg    = '0;
    req_bus.req_ba    = '0;
    req_bus.req_row   = '0;
    req_bus.req_col   = '0;
    cmd_bus.stall     = 1'b0;
    #3;
    apply_reset();

    // Closed-bank read, write hit on same row, row miss, stall during ACT_WAIT
    run_txn(1'b0, 2'd1, 2'd2, 17'h01234, 10'h040, 0, 0, -1);
    run_txn(1'b1, 2'd1, 2'd2, 17'h01234, 10'h123, 0, 0, -1);
    run_txn(1'b0, 2'd1, 2'd2, 17'h00055, 10'h3ff, 0, 0, -1);
    idle_cycles(2);
    run_txn(1'b0, 2'd0, 2'd1, 17'h00abc, 10'h011, 2, 3, -1);
    // Stall landing on a command cycle and in the middle of a burst
    run_txn(1'b1, 2'd0, 2'd1, 17'h00777, 10'h022, 1, 2, -1);
    run_txn(1'b0, 2'd0, 2'd1, 17'h00777, 10'h033, 8, 2, -1);

    for (int t = 0; t < 40; t++) begin
      wr  = 1'($urandom_range(0, 1));
      tbg = 2'($urandom_range(0, 3));
      tba = 2'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       trow = 17'h01234;
        1:       trow = 17'h00055;
        default: trow = AW'($urandom_range(0, 3)) << 8;
      endcase
      tcol = CW'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) begin
        s_start = $urandom_range(1, 14);
        s_len   = $urandom_range(1, 3);
      end else begin
        s_start = 0;
        s_len   = 0;
      end
      run_txn(wr, tbg, tba, trow, tcol, s_start, s_len, -1);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset in the middle of a burst, then the same bank/row must need an ACT again
    run_txn(1'b0, 2'd1, 2'd2, 17'h01234, 10'h040, 0, 0, 3);
    run_txn(1'b0, 2'd1, 2'd2, 17'h01234, 10'h040, 0, 0, -1);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
